// File: rtl/dcache_sram_arbiter_pkg.sv
// Arbiter-local types: the two-state ownership FSM encoding.
package dcache_sram_arbiter_pkg;
    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;
endpackage

// File: rtl/std_cache_pkg.sv
// Shared data-cache geometry and SRAM line types used by the cache controllers and arbiter.
package std_cache_pkg;
    localparam int DCACHE_SET_ASSOC   = 4;
    localparam int DCACHE_INDEX_WIDTH = 8;
    localparam int DCACHE_TAG_WIDTH   = 12;
    localparam int DCACHE_LINE_WIDTH  = 32;

    typedef logic [DCACHE_LINE_WIDTH-1:0]   cache_line_t;
    typedef logic [DCACHE_LINE_WIDTH/8-1:0] cl_be_t;

    function automatic int port_id_width(int nr_ports);
        return (nr_ports > 1) ? $clog2(nr_ports) : 1;
    endfunction
endpackage

// File: rtl/dcache_rr_picker.sv
// Round-robin pick among the cache ports (1..NR_PORTS-1), starting the search at ptr_i.
module dcache_rr_picker
    import std_cache_pkg::*;
#(
    parameter int NR_PORTS = 4,
    localparam int PW      = port_id_width(NR_PORTS)
) (
    input  logic [NR_PORTS-1:0] req_i,
    input  logic [PW-1:0]       ptr_i,
    output logic [PW-1:0]       idx_o,
    output logic                valid_o
);
    int p;

    // Scan farthest-to-nearest so the port closest to the pointer is the last hit and wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        p       = 0;
        for (int k = NR_PORTS - 2; k >= 0; k--) begin
            p = int'(ptr_i) + k;
            if (p > NR_PORTS - 1) begin
                p = p - (NR_PORTS - 1);
            end
            if (req_i[PW'(p)]) begin
                idx_o   = PW'(p);
                valid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dcache_sram_arbiter.sv
// Shares one data-cache SRAM between the snoop port (0) and the cache ports, with
// snoop priority, starvation relief for cache ports and an exclusive lock mode.
module dcache_sram_arbiter
    import std_cache_pkg::*;
    import dcache_sram_arbiter_pkg::*;
#(
    parameter int NR_PORTS     = 4,
    parameter int STARVE_LIMIT = 8,
    localparam int PW          = port_id_width(NR_PORTS),
    localparam int SW          = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                                                clk_i,
    input  logic                                                rst_i,
    input  logic [NR_PORTS-1:0][DCACHE_SET_ASSOC-1:0]           req_i,
    input  logic [NR_PORTS-1:0]                                 lock_i,
    input  logic [NR_PORTS-1:0][DCACHE_INDEX_WIDTH-1:0]         addr_i,
    input  logic [NR_PORTS-1:0][DCACHE_TAG_WIDTH-1:0]           tag_i,
    input  cache_line_t [NR_PORTS-1:0]                          data_i,
    input  cl_be_t [NR_PORTS-1:0]                               be_i,
    input  logic [NR_PORTS-1:0]                                 we_i,
    output logic [NR_PORTS-1:0]                                 gnt_o,
    output logic [NR_PORTS-1:0]                                 rvalid_o,
    output logic [DCACHE_SET_ASSOC-1:0]                         req_o,
    output logic [DCACHE_INDEX_WIDTH-1:0]                       addr_o,
    output logic [DCACHE_TAG_WIDTH-1:0]                         tag_o,
    output cache_line_t                                         data_o,
    output cl_be_t                                              be_o,
    output logic                                                we_o,
    input  logic                                                gnt_i
);
    arb_state_e          state_q, state_d;
    logic [PW-1:0]       owner_q, owner_d;
    logic [PW-1:0]       tag_sel_q, tag_sel_d;
    logic [SW-1:0]       starve_cnt_q, starve_cnt_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NR_PORTS-1:0] rvalid_q, rvalid_d;

    logic [NR_PORTS-1:0] port_req;
    logic [NR_PORTS-1:0] cache_req;
    logic [PW-1:0]       rr_idx;
    logic                rr_valid;
    logic [PW-1:0]       win_idx;
    logic                win_valid;
    logic                granted;

    always_comb begin
        for (int p = 0; p < NR_PORTS; p++) begin
            port_req[p] = |req_i[p];
        end
        cache_req    = port_req;
        cache_req[0] = 1'b0;
    end

    dcache_rr_picker #(
        .NR_PORTS (NR_PORTS)
    ) u_rr_picker (
        .req_i   (cache_req),
        .ptr_i   (rr_ptr_q),
        .idx_o   (rr_idx),
        .valid_o (rr_valid)
    );

    // Reset suppresses any winner so a lock abandoned by reset issues no further grant.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        if (!rst_i) begin
            if (state_q == LOCK) begin
                win_valid = port_req[owner_q];
                win_idx   = owner_q;
            end else if (rr_valid && (starve_cnt_q == SW'(STARVE_LIMIT))) begin
                win_valid = 1'b1;
                win_idx   = rr_idx;
            end else if (port_req[0]) begin
                win_valid = 1'b1;
                win_idx   = '0;
            end else if (rr_valid) begin
                win_valid = 1'b1;
                win_idx   = rr_idx;
            end
        end
        granted = win_valid & gnt_i;
    end

    always_comb begin
        gnt_o  = '0;
        req_o  = '0;
        addr_o = '0;
        data_o = '0;
        be_o   = '0;
        we_o   = 1'b0;
        if (win_valid) begin
            gnt_o[win_idx] = gnt_i;
            req_o          = req_i[win_idx];
            addr_o         = addr_i[win_idx];
            data_o         = data_i[win_idx];
            be_o           = be_i[win_idx];
            we_o           = we_i[win_idx];
        end
        tag_o    = tag_i[tag_sel_q];
        rvalid_o = rvalid_q;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        tag_sel_d    = tag_sel_q;
        starve_cnt_d = starve_cnt_q;
        rr_ptr_d     = rr_ptr_q;
        rvalid_d     = '0;
        if (granted) begin
            tag_sel_d         = win_idx;
            rvalid_d[win_idx] = ~we_i[win_idx];
            if (win_idx == '0) begin
                if ((|cache_req) && (starve_cnt_q != SW'(STARVE_LIMIT))) begin
                    starve_cnt_d = starve_cnt_q + SW'(1);
                end
            end else begin
                starve_cnt_d = '0;
                rr_ptr_d     = (win_idx == PW'(NR_PORTS - 1)) ? PW'(1) : win_idx + PW'(1);
            end
            if ((state_q == ARB) && lock_i[win_idx]) begin
                state_d = LOCK;
                owner_d = win_idx;
            end
        end
        // A stalled final owner request keeps the lock until the SRAM takes it.
        if ((state_q == LOCK) && !lock_i[owner_q] && (!win_valid || gnt_i)) begin
            state_d = ARB;
            owner_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ARB;
            owner_q      <= '0;
            tag_sel_q    <= '0;
            starve_cnt_q <= '0;
            rr_ptr_q     <= PW'(1);
            rvalid_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            tag_sel_q    <= tag_sel_d;
            starve_cnt_q <= starve_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            rvalid_q     <= rvalid_d;
        end
    end
endmodule

// File: tb/tb_dcache_sram_arbiter.sv
// Self-checking bench for dcache_sram_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the arbitration rules.
module tb_dcache_sram_arbiter;
    import std_cache_pkg::*;

    localparam int NP     = 4;
    localparam int SA     = DCACHE_SET_ASSOC;
    localparam int STARVE = 8;

    logic clk = 1'b0;
    logic rst;
    logic [NP-1:0][SA-1:0]                 req;
    logic [NP-1:0]                         lock;
    logic [NP-1:0][DCACHE_INDEX_WIDTH-1:0] addr;
    logic [NP-1:0][DCACHE_TAG_WIDTH-1:0]   tag;
    cache_line_t [NP-1:0]                  data;
    cl_be_t [NP-1:0]                       be;
    logic [NP-1:0]                         we;
    logic                                  gnt;

    logic [NP-1:0]                 gnt_o;
    logic [NP-1:0]                 rvalid_o;
    logic [SA-1:0]                 req_o;
    logic [DCACHE_INDEX_WIDTH-1:0] addr_o;
    logic [DCACHE_TAG_WIDTH-1:0]   tag_o;
    cache_line_t                   data_o;
    cl_be_t                        be_o;
    logic                          we_o;

    dcache_sram_arbiter #(
        .NR_PORTS     (NP),
        .STARVE_LIMIT (STARVE)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req),
        .lock_i   (lock),
        .addr_i   (addr),
        .tag_i    (tag),
        .data_i   (data),
        .be_i     (be),
        .we_i     (we),
        .gnt_o    (gnt_o),
        .rvalid_o (rvalid_o),
        .req_o    (req_o),
        .addr_o   (addr_o),
        .tag_o    (tag_o),
        .data_o   (data_o),
        .be_o     (be_o),
        .we_o     (we_o),
        .gnt_i    (gnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit          m_locked = 1'b0;
    int          m_owner  = 0;
    int          m_starve = 0;
    int          m_ptr    = 1;
    int          m_tagsel = 0;
    logic [NP-1:0] m_rvalid = '0;

    logic [NP-1:0]               s_gnt;
    logic [NP-1:0]               s_rvalid;
    logic [DCACHE_TAG_WIDTH-1:0] s_tag;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic bit wants(int p);
        return |req[p];
    endfunction

    function automatic bit any_cache();
        for (int p = 1; p < NP; p++) if (wants(p)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int rr_pick();
        int p;
        for (int k = 0; k < NP - 1; k++) begin
            p = m_ptr + k;
            if (p > NP - 1) p = p - (NP - 1);
            if (wants(p)) return p;
        end
        return -1;
    endfunction

    function automatic int exp_winner();
        int cw;
        if (rst) return -1;
        if (m_locked) return wants(m_owner) ? m_owner : -1;
        cw = rr_pick();
        if (cw >= 0 && m_starve == STARVE) return cw;
        if (wants(0)) return 0;
        return cw;
    endfunction

    // One cycle: compare outputs mid-cycle, then advance the model across the clock edge.
    task automatic step();
        int w;
        logic [NP-1:0] eg;
        bit g, ex;
        #1;
        w  = exp_winner();
        eg = '0;
        if (w >= 0 && gnt) eg[w] = 1'b1;
        chk("gnt_o", gnt_o, eg);
        chk("req_o", req_o, (w >= 0) ? req[w] : '0);
        chk("we_o", we_o, (w >= 0) ? we[w] : 1'b0);
        chk("addr_o", addr_o, (w >= 0) ? addr[w] : '0);
        chk("data_o", data_o, (w >= 0) ? data[w] : '0);
        chk("be_o", be_o, (w >= 0) ? be[w] : '0);
        if (!rst) begin
            chk("rvalid_o", rvalid_o, m_rvalid);
            chk("tag_o", tag_o, tag[m_tagsel]);
        end
        s_gnt    = gnt_o;
        s_rvalid = rvalid_o;
        s_tag    = tag_o;
        @(posedge clk);
        if (rst) begin
            m_locked = 1'b0; m_owner = 0; m_starve = 0; m_ptr = 1; m_tagsel = 0; m_rvalid = '0;
        end else begin
            g  = (w >= 0) && gnt;
            ex = m_locked && !lock[m_owner] && (w < 0 || gnt);
            m_rvalid = '0;
            if (g) begin
                if (!we[w]) m_rvalid[w] = 1'b1;
                m_tagsel = w;
                if (w == 0) begin
                    if (any_cache() && m_starve < STARVE) m_starve++;
                end else begin
                    m_starve = 0;
                    m_ptr    = (w == NP - 1) ? 1 : w + 1;
                end
                if (!m_locked && lock[w]) begin
                    m_locked = 1'b1;
                    m_owner  = w;
                end
            end
            if (ex) begin
                m_locked = 1'b0;
                m_owner  = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req  = '0;
        lock = '0;
        we   = '0;
        gnt  = 1'b1;
        for (int p = 0; p < NP; p++) begin
            addr[p] = DCACHE_INDEX_WIDTH'(8'h10 + p);
            tag[p]  = DCACHE_TAG_WIDTH'(12'hA00 + p);
            data[p] = cache_line_t'(32'hD000_0000 + p);
            be[p]   = cl_be_t'(4'hF);
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        do_reset();

        // Quiet after reset
        step();
        chk("post_reset_gnt", s_gnt, '0);
        chk("post_reset_rvalid", s_rvalid, '0);

        // Snoop priority over cache port, read data/tag one cycle later
        req[0] = 4'b0001;
        req[2] = 4'b0010;
        step();
        chk("snoop_prio_gnt", s_gnt, 4'b0001);
        req = '0;
        step();
        chk("snoop_rvalid", s_rvalid, 4'b0001);
        chk("snoop_tag", s_tag, 12'hA00);

        // Starvation relief
        do_reset();
        req[0] = 4'b0001;
        req[1] = 4'b0100;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c <= 8) chk("starve_p0_gnt", s_gnt, 4'b0001);
            if (c == 8) chk("model_starve_sat", m_starve, STARVE);
            if (c == 9) begin
                chk("starve_p1_gnt", s_gnt, 4'b0010);
                chk("model_starve_clr", m_starve, 0);
            end
            if (c == 10) chk("starve_p0_again", s_gnt, 4'b0001);
        end

        // Lock held by port 0 blocks port 3 until the cycle after lock falls
        do_reset();
        req[0] = 4'b0001; lock[0] = 1'b1; req[3] = 4'b1000;
        step();
        chk("lock_first_gnt", s_gnt, 4'b0001);
        req[0] = '0;
        step();
        chk("lock_hold1", s_gnt, 4'b0000);
        step();
        chk("lock_hold2", s_gnt, 4'b0000);
        req[0] = 4'b0001; we[0] = 1'b1; lock[0] = 1'b0;
        step();
        chk("lock_final_write", s_gnt, 4'b0001);
        req[0] = '0; we[0] = 1'b0;
        step();
        chk("lock_release_p3", s_gnt, 4'b1000);

        // Round-robin wrap among cache ports
        do_reset();
        req[1] = 4'b0001; req[2] = 4'b0001; req[3] = 4'b0001;
        step(); chk("rr_1", s_gnt, 4'b0010);
        step(); chk("rr_2", s_gnt, 4'b0100);
        step(); chk("rr_3", s_gnt, 4'b1000);
        step(); chk("rr_wrap", s_gnt, 4'b0010);

        // SRAM backpressure holds the request and all state
        do_reset();
        req[2] = 4'b0010; gnt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stall_gnt", s_gnt, 4'b0000);
        end
        chk("stall_model_ptr", m_ptr, 1);
        gnt = 1'b1;
        step();
        chk("stall_release", s_gnt, 4'b0100);

        // Reset in the middle of a lock
        do_reset();
        req[0] = 4'b0001; lock[0] = 1'b1;
        step();
        chk("rstlock_gnt", s_gnt, 4'b0001);
        req[0] = '0; req[1] = 4'b0001;
        step();
        chk("rstlock_blocked", s_gnt, 4'b0000);
        rst = 1'b1;
        step();
        chk("rstlock_during", s_gnt, 4'b0000);
        rst = 1'b0; lock[0] = 1'b0;
        step();
        chk("rstlock_after_gnt", s_gnt, 4'b0010);
        chk("rstlock_after_rvalid", s_rvalid, 4'b0000);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < NP; p++) begin
                req[p]  = ($urandom_range(0, 2) == 0) ? SA'($urandom_range(1, 15)) : '0;
                lock[p] = ($urandom_range(0, 3) == 0);
                we[p]   = $urandom_range(0, 1) == 1;
                addr[p] = DCACHE_INDEX_WIDTH'($urandom);
                tag[p]  = DCACHE_TAG_WIDTH'($urandom);
                data[p] = cache_line_t'($urandom);
                be[p]   = cl_be_t'($urandom);
            end
            gnt = ($urandom_range(0, 4) != 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
